// File: rtl/rf_writeback_ctrl.sv
// Write-port controller for the 3-port register file: merges ALU results and load responses
// into one registered write, and tracks per-register pending loads for decode's RAW check.
module rf_writeback_ctrl #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int LQ_DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [RFIDX_WIDTH-1:0] alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  input  logic                   iss_valid,
  output logic                   iss_ready,
  input  logic [RFIDX_WIDTH-1:0] iss_rd,
  input  logic                   lsu_valid,
  input  logic [RFIDX_WIDTH-1:0] lsu_rd,
  input  logic [XLEN-1:0]        lsu_data,
  input  logic [RFIDX_WIDTH-1:0] chk_rs1,
  input  logic [RFIDX_WIDTH-1:0] chk_rs2,
  output logic                   chk_hazard,
  output logic                   rf_we,
  output logic [RFIDX_WIDTH-1:0] rf_wa,
  output logic [XLEN-1:0]        rf_wd
);

  localparam int NREGS = 2 ** RFIDX_WIDTH;
  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] LQ_MAX = CNT_W'(LQ_DEPTH);

  // Handshakes: a transfer happens on a cycle where valid && ready are both high at posedge.
  // alu_ready/iss_ready never depend on their own valid; the LSU port has no ready and must
  // never present a response that was not previously issued.

  logic [NREGS-1:0]       pending_q, pending_d;
  logic [CNT_W-1:0]       outstanding_q, outstanding_d;
  logic [CNT_W-1:0]       lq_cnt_q, lq_cnt_d;
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [RFIDX_WIDTH-1:0] lq_rd   [LQ_DEPTH];
  logic [XLEN-1:0]        lq_data [LQ_DEPTH];

  logic                   lq_full, lq_empty;
  logic                   push, pop, alu_win, iss_fire;
  logic [RFIDX_WIDTH-1:0] head_rd;
  logic [XLEN-1:0]        head_data;

  assign lq_full   = (lq_cnt_q == LQ_MAX);
  assign lq_empty  = (lq_cnt_q == '0);
  assign head_rd   = lq_rd[rd_ptr_q];
  assign head_data = lq_data[rd_ptr_q];

  // A full queue always takes the slot so outstanding loads can never deadlock behind ALU traffic.
  assign alu_ready = !lq_full;
  assign alu_win   = alu_valid && !lq_full;
  assign pop       = lq_full || (!alu_valid && !lq_empty);
  assign push      = lsu_valid && !lq_full;

  assign iss_ready = !pending_q[iss_rd] && (outstanding_q < LQ_MAX);
  assign iss_fire  = iss_valid && iss_ready;

  assign chk_hazard = ((chk_rs1 != '0) && pending_q[chk_rs1]) ||
                      ((chk_rs2 != '0) && pending_q[chk_rs2]);

  // Clear before set so a retire and a new issue to the same rd leave the bit set.
  always_comb begin
    pending_d = pending_q;
    if (pop) begin
      pending_d[head_rd] = 1'b0;
    end
    if (iss_fire && (iss_rd != '0)) begin
      pending_d[iss_rd] = 1'b1;
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    case ({iss_fire, pop})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_comb begin
    lq_cnt_d = lq_cnt_q;
    case ({push, pop})
      2'b10:   lq_cnt_d = lq_cnt_q + CNT_W'(1);
      2'b01:   lq_cnt_d = lq_cnt_q - CNT_W'(1);
      default: lq_cnt_d = lq_cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q     <= '0;
      outstanding_q <= '0;
      lq_cnt_q      <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      lq_cnt_q      <= lq_cnt_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Queue storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (push) begin
      lq_rd[wr_ptr_q]   <= lsu_rd;
      lq_data[wr_ptr_q] <= lsu_data;
    end
  end

  // Winner registered here; x0 consumes the slot without raising the write enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else if (alu_win) begin
      rf_we <= (alu_rd != '0);
      rf_wa <= alu_rd;
      rf_wd <= alu_data;
    end else if (pop) begin
      rf_we <= (head_rd != '0);
      rf_wa <= head_rd;
      rf_wd <= head_data;
    end else begin
      rf_we <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!reset && lsu_valid) begin
      assert (!lq_full)
        else $error("rf_writeback_ctrl: load response while queue full, dropped (rd=%0d)", lsu_rd);
    end
  end

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Self-checking bench for rf_writeback_ctrl: scenario tasks plus a write-port scoreboard
// that compares each rf_we pulse against the expected {wa,wd} queue.
module tb_rf_writeback_ctrl;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int W    = RW + XLEN;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_valid, alu_ready;
  logic [RW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            iss_valid, iss_ready;
  logic [RW-1:0]   iss_rd;
  logic            lsu_valid;
  logic [RW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic [RW-1:0]   chk_rs1, chk_rs2;
  logic            chk_hazard;
  logic            rf_we;
  logic [RW-1:0]   rf_wa;
  logic [XLEN-1:0] rf_wd;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  rf_writeback_ctrl #(.XLEN(XLEN), .RFIDX_WIDTH(RW), .LQ_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_hazard(chk_hazard),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && rf_we) begin
      logic [W-1:0] e;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wb_unexpected: got write wa=%0d wd=%h, required no write", rf_wa, rf_wd);
      end else begin
        e = exp_q.pop_front();
        if ({rf_wa, rf_wd} !== e) begin
          n_err++;
          $display("FAIL wb_data: got wa=%0d wd=%h, required wa=%0d wd=%h",
                   rf_wa, rf_wd, e[W-1:XLEN], e[XLEN-1:0]);
        end
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d writes still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    chk_rs1 = '0; chk_rs2 = '0;
  endtask

  task automatic issue_load(input logic [RW-1:0] rd, input logic exp_ready);
    iss_valid = 1'b1; iss_rd = rd;
    #1;
    n_vec++;
    if (iss_ready !== exp_ready) begin
      n_err++;
      $display("FAIL iss_ready_x%0d: got %b, required %b", rd, iss_ready, exp_ready);
    end
    if (exp_ready) tick();
    iss_valid = 1'b0;
  endtask

  task automatic lsu_respond(input logic [RW-1:0] rd, input logic [XLEN-1:0] d);
    lsu_valid = 1'b1; lsu_rd = rd; lsu_data = d;
    if (rd != '0) exp_q.push_back({rd, d});
    tick();
    lsu_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    chk_rs1 = 5'd3; chk_rs2 = 5'd4;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({rf_we, rf_wa, rf_wd} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got we=%b wa=%0d wd=%h, required 0/0/0", rf_we, rf_wa, rf_wd);
    end
    n_vec++;
    if (chk_hazard !== 1'b0 || iss_ready !== 1'b1 || alu_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_status: got hazard=%b iss_ready=%b alu_ready=%b, required 0/1/1",
               chk_hazard, iss_ready, alu_ready);
    end
    reset = 1'b0;
    chk_rs1 = '0; chk_rs2 = '0;
    tick();
  endtask

  task automatic test_alu_write();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    #1;
    n_vec++;
    if (alu_ready !== 1'b1) begin
      n_err++;
      $display("FAIL alu_ready_x5: got %b, required 1", alu_ready);
    end
    exp_q.push_back({5'd5, 32'h1234});
    tick();
    alu_valid = 1'b0;
    #1;
    n_vec++;
    if (rf_we !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 32'h1234) begin
      n_err++;
      $display("FAIL alu_latency: got we=%b wa=%0d wd=%h, required 1/5/00001234", rf_we, rf_wa, rf_wd);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      logic [RW-1:0]   rd;
      logic [XLEN-1:0] d;
      rd = RW'($urandom_range(0, 31));
      d  = $urandom;
      alu_valid = 1'b1; alu_rd = rd; alu_data = d;
      #1;
      n_vec++;
      if (alu_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_alu_ready_%0d: got %b, required 1", i, alu_ready);
      end
      if (rd != '0) exp_q.push_back({rd, d});
      tick();
    end
    alu_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_load_hazard();
    issue_load(5'd7, 1'b1);
    chk_rs1 = 5'd7; chk_rs2 = 5'd0;
    #1;
    n_vec++;
    if (chk_hazard !== 1'b1) begin
      n_err++;
      $display("FAIL hazard_rs1_x7: got %b, required 1", chk_hazard);
    end
    chk_rs1 = 5'd0; chk_rs2 = 5'd7;
    #1;
    n_vec++;
    if (chk_hazard !== 1'b1) begin
      n_err++;
      $display("FAIL hazard_rs2_x7: got %b, required 1", chk_hazard);
    end
    issue_load(5'd7, 1'b0);
    lsu_respond(5'd7, 32'hBEEF);
    #1;
    n_vec++;
    if (chk_hazard !== 1'b1) begin
      n_err++;
      $display("FAIL hazard_after_push: got %b, required 1", chk_hazard);
    end
    tick();
    n_vec++;
    if (chk_hazard !== 1'b0) begin
      n_err++;
      $display("FAIL hazard_after_retire: got %b, required 0", chk_hazard);
    end
    chk_rs2 = '0;
    wait_drain();
  endtask

  task automatic test_fifo_full();
    logic [XLEN-1:0] ld [4];
    logic [XLEN-1:0] a;
    for (int i = 0; i < 4; i++) issue_load(RW'(i + 1), 1'b1);
    issue_load(5'd5, 1'b0);
    alu_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_rd = RW'(10 + i); alu_data = $urandom;
      ld[i] = $urandom;
      lsu_valid = 1'b1; lsu_rd = RW'(i + 1); lsu_data = ld[i];
      #1;
      n_vec++;
      if (alu_ready !== 1'b1) begin
        n_err++;
        $display("FAIL full_alu_ready_%0d: got %b, required 1", i, alu_ready);
      end
      exp_q.push_back({alu_rd, alu_data});
      tick();
    end
    lsu_valid = 1'b0;
    a = $urandom;
    alu_rd = 5'd14; alu_data = a;
    #1;
    n_vec++;
    if (alu_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_alu_blocked: got %b, required 0", alu_ready);
    end
    exp_q.push_back({5'd1, ld[0]});
    tick();
    n_vec++;
    if (alu_ready !== 1'b1) begin
      n_err++;
      $display("FAIL full_alu_resume: got %b, required 1", alu_ready);
    end
    exp_q.push_back({5'd14, a});
    tick();
    alu_valid = 1'b0;
    for (int i = 1; i < 4; i++) exp_q.push_back({RW'(i + 1), ld[i]});
    wait_drain();
    chk_rs1 = 5'd1; chk_rs2 = 5'd4; iss_rd = 5'd5;
    #1;
    n_vec++;
    if (chk_hazard !== 1'b0 || iss_ready !== 1'b1) begin
      n_err++;
      $display("FAIL full_cleanup: got hazard=%b iss_ready=%b, required 0/1", chk_hazard, iss_ready);
    end
    chk_rs1 = '0; chk_rs2 = '0;
  endtask

  task automatic test_x0();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
    #1;
    n_vec++;
    if (alu_ready !== 1'b1) begin
      n_err++;
      $display("FAIL x0_alu_ready: got %b, required 1", alu_ready);
    end
    tick();
    alu_valid = 1'b0;
    issue_load(5'd0, 1'b1);
    lsu_respond(5'd0, $urandom);
    tick();
    tick();
    for (int i = 20; i < 24; i++) issue_load(RW'(i), 1'b1);
    issue_load(5'd24, 1'b0);
    for (int i = 23; i >= 20; i--) lsu_respond(RW'(i), $urandom);
    wait_drain();
    chk_rs1 = 5'd20; chk_rs2 = 5'd23;
    #1;
    n_vec++;
    if (chk_hazard !== 1'b0) begin
      n_err++;
      $display("FAIL x0_cleanup_hazard: got %b, required 0", chk_hazard);
    end
    chk_rs1 = '0; chk_rs2 = '0;
  endtask

  task automatic test_pop_issue_same_rd();
    issue_load(5'd9, 1'b1);
    lsu_respond(5'd9, 32'h9999_0001);
    iss_valid = 1'b1; iss_rd = 5'd9;
    #1;
    n_vec++;
    if (iss_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reissue_blocked_x9: got %b, required 0", iss_ready);
    end
    tick();
    n_vec++;
    if (iss_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reissue_ready_x9: got %b, required 1", iss_ready);
    end
    tick();
    iss_valid = 1'b0;
    chk_rs1 = 5'd0; chk_rs2 = 5'd9;
    #1;
    n_vec++;
    if (chk_hazard !== 1'b1) begin
      n_err++;
      $display("FAIL reissue_hazard_x9: got %b, required 1", chk_hazard);
    end
    lsu_respond(5'd9, 32'h9999_0002);
    wait_drain();
    n_vec++;
    if (chk_hazard !== 1'b0) begin
      n_err++;
      $display("FAIL reissue_cleared_x9: got %b, required 0", chk_hazard);
    end
    chk_rs2 = '0;
  endtask

  task automatic test_reset_mid();
    issue_load(5'd11, 1'b1);
    issue_load(5'd12, 1'b1);
    issue_load(5'd13, 1'b1);
    alu_valid = 1'b1; alu_rd = 5'd14; alu_data = 32'hCAFE_F00D;
    exp_q.push_back({5'd14, 32'hCAFE_F00D});
    tick();
    alu_valid = 1'b0;
    chk_rs1 = 5'd11; chk_rs2 = 5'd12; iss_rd = 5'd13;
    #1;
    n_vec++;
    if (rf_we !== 1'b1 || chk_hazard !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_state: got we=%b hazard=%b, required 1/1", rf_we, chk_hazard);
    end
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({rf_we, rf_wa, rf_wd} !== '0) begin
      n_err++;
      $display("FAIL async_reset_outputs: got we=%b wa=%0d wd=%h, required 0/0/0", rf_we, rf_wa, rf_wd);
    end
    n_vec++;
    if (chk_hazard !== 1'b0 || iss_ready !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset_status: got hazard=%b iss_ready=%b, required 0/1", chk_hazard, iss_ready);
    end
    repeat (2) tick();
    reset = 1'b0;
    chk_rs1 = '0; chk_rs2 = '0;
    tick();
    for (int i = 1; i < 5; i++) issue_load(RW'(i), 1'b1);
    issue_load(5'd5, 1'b0);
    for (int i = 1; i < 5; i++) lsu_respond(RW'(i), $urandom);
    wait_drain();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_alu_write();
    test_back_to_back();
    test_load_hazard();
    test_fifo_full();
    test_x0();
    test_pop_issue_same_rd();
    test_reset_mid();
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
